// File: rtl/seg_req_if.sv
// -----------------------------------------------------------------------------
// seg_req_if
// One requester's frame handshake toward seg_display_arbiter.
//   valid : requester has a frame to display (held until ready is seen)
//   bcd   : four BCD digits, [3:0] is the rightmost digit
//   dp    : decimal points, active-low (1 = off)
//   ready : frame is accepted at the coming clock edge
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface seg_req_if;
  logic        valid;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        ready;

  modport master (output valid, output bcd, output dp, input ready);
  modport slave  (input valid, input bcd, input dp, output ready);
endinterface

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit seven-segment display driver between two requesters.
// Grants are round-robin. An accepted frame stays on the display for at least
// HOLD_CYCLES. A change of owner inserts GAP_CYCLES of blanking first.
//
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   req0     : requester 0 handshake (seg_req_if.slave)
//   req1     : requester 1 handshake (seg_req_if.slave)
//   bcd_out  : registered digits to the display driver
//   dp_out   : registered decimal points, active-low
//   blank    : 1 = display dark
//   owner    : requester whose frame is currently shown
//   busy     : 1 while in HOLD or GAP
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 10_000_000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic          clk,
  input  logic          reset,
  seg_req_if.slave      req0,
  seg_req_if.slave      req1,
  output logic [15:0]   bcd_out,
  output logic [3:0]    dp_out,
  output logic          blank,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_LINGER,
    S_GAP
  } state_t;

  // Terminal counts: the counter runs 0..LAST inside a state, then leaves it.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit               GAP_EN    = (GAP_CYCLES != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_owner;
  logic [15:0]      pend_bcd;
  logic [3:0]       pend_dp;

  logic             accept_window;
  logic             grant_valid;
  logic             grant_idx;
  logic [15:0]      sel_bcd;
  logic [3:0]       sel_dp;
  logic [CNT_W-1:0] cnt_inc;

  // Round-robin grant: on a tie the requester that did not win last time goes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    accept_window = (state == S_IDLE) || (state == S_LINGER);
    grant_valid   = req0.valid | req1.valid;
    grant_idx     = 1'b0;
    if (req0.valid && req1.valid) begin
      grant_idx = ~last_owner;
    end else if (req1.valid) begin
      grant_idx = 1'b1;
    end
    sel_bcd = grant_idx ? req1.bcd : req0.bcd;
    sel_dp  = grant_idx ? req1.dp  : req0.dp;
  end

  assign req0.ready = accept_window & grant_valid & ~grant_idx;
  assign req1.ready = accept_window & grant_valid &  grant_idx;

  // Saturating increment; the counter never wraps.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the pending frame registers are reset too, so a frame captured
      // before reset can never leak onto the display afterwards.
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      pend_bcd   <= 16'h0000;
      pend_dp    <= 4'hF;
      bcd_out    <= 16'h0000;
      dp_out     <= 4'hF;
      blank      <= 1'b1;
      owner      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_LINGER: begin
          if (accept_window && grant_valid) begin
            pend_bcd   <= sel_bcd;
            pend_dp    <= sel_dp;
            last_owner <= grant_idx;
            cnt        <= '0;
            busy       <= 1'b1;
            // Same owner (or nothing shown yet): show the new frame at once.
            if (state == S_IDLE || grant_idx == owner || !GAP_EN) begin
              bcd_out <= sel_bcd;
              dp_out  <= sel_dp;
              owner   <= grant_idx;
              blank   <= 1'b0;
              state   <= S_HOLD;
            end else begin
              // Owner change: go dark, keep the old digits latched meanwhile.
              blank <= 1'b1;
              state <= S_GAP;
            end
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_LINGER;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            // last_owner already names the requester whose frame is pending.
            bcd_out <= pend_bcd;
            dp_out  <= pend_dp;
            owner   <= last_owner;
            blank   <= 1'b0;
            cnt     <= '0;
            state   <= S_HOLD;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          blank <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Directed stimulus with HOLD_CYCLES=8, GAP_CYCLES=3. The stimulus process
// queues every display update it expects (blank, owner, digits, points, busy,
// and optionally how many cycles the previous display state lasted). A monitor
// samples on the falling edge, and whenever the observed tuple changes it pops
// the queue and compares. Handshake ready levels are checked inline.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

  localparam int unsigned HOLD = 8;
  localparam int unsigned GAP  = 3;

  typedef struct packed {
    logic        blank;
    logic        owner;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        busy;
  } obs_t;

  typedef struct {
    obs_t obs;
    int   dwell;  // cycles the previous tuple lasted; -1 = don't care
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic        blank;
  logic        owner;
  logic        busy;

  seg_req_if req0_if ();
  seg_req_if req1_if ();

  seg_display_arbiter #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0_if),
    .req1    (req1_if),
    .bcd_out (bcd_out),
    .dp_out  (dp_out),
    .blank   (blank),
    .owner   (owner),
    .busy    (busy)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic b, input logic o, input logic [15:0] d,
                      input logic [3:0] p, input logic bz, input int dwell);
    exp_t e;
    e.obs   = '{blank: b, owner: o, bcd: d, dp: p, busy: bz};
    e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a falling edge with busy low, then moves to just
  // after the next rising edge so inputs can be driven.
  task automatic wait_not_busy();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("wait_not_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each change of the observed display tuple.
  int   cyc = 0;
  int   last_cyc = 0;
  obs_t prev_obs;
  obs_t cur_obs;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc++;
    cur_obs = '{blank: blank, owner: owner, bcd: bcd_out, dp: dp_out, busy: busy};
    if (reset) begin
      prev_obs = cur_obs;
      last_cyc = cyc;
    end else if (cur_obs !== prev_obs) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: actual=%h required=no change from %h", cur_obs, prev_obs);
      end else begin
        mon_e = exp_q.pop_front();
        check("display_tuple", 32'(cur_obs), 32'(mon_e.obs));
        if (mon_e.dwell >= 0) check("dwell_cycles", cyc - last_cyc, mon_e.dwell);
      end
      prev_obs = cur_obs;
      last_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stream table: expected grant order and frames under continuous dual requests.
  logic        s_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] s_bcd   [4] = '{16'hA0A0, 16'hB1B1, 16'hA2A2, 16'hB3B3};
  logic [3:0]  s_dp    [4] = '{4'b1110, 4'b1101, 4'b1110, 4'b1101};

  initial begin
    logic        p_owner;
    logic [15:0] p_bcd;
    logic [3:0]  p_dp;

    reset = 1'b1;
    req0_if.valid = 1'b0; req0_if.bcd = '0; req0_if.dp = 4'hF;
    req1_if.valid = 1'b0; req1_if.bcd = '0; req1_if.dp = 4'hF;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_bcd",    32'(bcd_out), 32'h0000);
    check("rst_dp",     32'(dp_out),  32'hF);
    check("rst_blank",  32'(blank),   32'd1);
    check("rst_owner",  32'(owner),   32'd0);
    check("rst_busy",   32'(busy),    32'd0);
    check("rst_ready0", 32'(req0_if.ready), 32'd0);
    check("rst_ready1", 32'(req1_if.ready), 32'd0);

    // First frame from IDLE, then a same-owner resubmit held through HOLD
    @(posedge clk); #1;
    req0_if.valid = 1'b1; req0_if.bcd = 16'h1234; req0_if.dp = 4'b1011;
    push(1'b0, 1'b0, 16'h1234, 4'b1011, 1'b1, -1);
    push(1'b0, 1'b0, 16'h1234, 4'b1011, 1'b0, HOLD);
    push(1'b0, 1'b0, 16'h5678, 4'b0111, 1'b1, 1);
    push(1'b0, 1'b0, 16'h5678, 4'b0111, 1'b0, HOLD);
    @(negedge clk);
    check("idle_ready0", 32'(req0_if.ready), 32'd1);
    check("idle_ready1", 32'(req1_if.ready), 32'd0);
    @(posedge clk); #1;
    req0_if.bcd = 16'h5678; req0_if.dp = 4'b0111;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check("hold_ready0", 32'(req0_if.ready), 32'd0);
    end
    @(negedge clk);
    check("linger_ready0", 32'(req0_if.ready), 32'd1);
    @(posedge clk); #1;
    req0_if.valid = 1'b0;
    wait_not_busy();

    // Tie from IDLE: req0 first, req1 on the first LINGER cycle via a gap
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    req0_if.valid = 1'b1; req0_if.bcd = 16'h1111; req0_if.dp = 4'hF;
    req1_if.valid = 1'b1; req1_if.bcd = 16'h2222; req1_if.dp = 4'hF;
    push(1'b0, 1'b0, 16'h1111, 4'hF, 1'b1, -1);
    push(1'b0, 1'b0, 16'h1111, 4'hF, 1'b0, HOLD);
    push(1'b1, 1'b0, 16'h1111, 4'hF, 1'b1, 1);
    push(1'b0, 1'b1, 16'h2222, 4'hF, 1'b1, GAP);
    push(1'b0, 1'b1, 16'h2222, 4'hF, 1'b0, HOLD);
    @(negedge clk);
    check("tie_ready0", 32'(req0_if.ready), 32'd1);
    check("tie_ready1", 32'(req1_if.ready), 32'd0);
    @(posedge clk); #1;
    req0_if.valid = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check("hold_ready1", 32'(req1_if.ready), 32'd0);
    end
    @(negedge clk);
    check("linger_ready1", 32'(req1_if.ready), 32'd1);
    @(posedge clk); #1;
    req1_if.valid = 1'b0;
    wait_not_busy();

    // Continuous dual requests alternate owners starting with req0
    p_owner = 1'b1; p_bcd = 16'h2222; p_dp = 4'hF;
    for (int k = 0; k < 4; k++) begin
      push(1'b1, p_owner, p_bcd, p_dp, 1'b1, -1);
      push(1'b0, s_grant[k], s_bcd[k], s_dp[k], 1'b1, GAP);
      push(1'b0, s_grant[k], s_bcd[k], s_dp[k], 1'b0, HOLD);
      p_owner = s_grant[k]; p_bcd = s_bcd[k]; p_dp = s_dp[k];
    end
    req0_if.valid = 1'b1; req0_if.bcd = 16'hA0A0; req0_if.dp = 4'b1110;
    req1_if.valid = 1'b1; req1_if.bcd = 16'hB1B1; req1_if.dp = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (req0_if.ready || req1_if.ready) break;
      end
      check("stream_grant", {30'd0, req1_if.ready, req0_if.ready},
            s_grant[k] ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      if (k == 0) req0_if.bcd = 16'hA2A2;
      if (k == 1) req1_if.bcd = 16'hB3B3;
      if (k == 2) req0_if.bcd = 16'hA4A4;
    end
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    wait_not_busy();

    // Reset during GAP discards the pending frame
    req0_if.valid = 1'b1; req0_if.bcd = 16'hC0C0; req0_if.dp = 4'b0000;
    push(1'b1, 1'b1, 16'hB3B3, 4'b1101, 1'b1, -1);
    @(negedge clk);
    check("gap_ready0", 32'(req0_if.ready), 32'd1);
    @(posedge clk); #1;
    req0_if.valid = 1'b0;
    @(negedge clk);
    check("gap_blank", 32'(blank), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_gap_bcd",   32'(bcd_out), 32'h0000);
    check("rst_gap_dp",    32'(dp_out),  32'hF);
    check("rst_gap_blank", 32'(blank),   32'd1);
    check("rst_gap_owner", 32'(owner),   32'd0);
    check("rst_gap_busy",  32'(busy),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_bcd",   32'(bcd_out), 32'h0000);
    check("post_rst_blank", 32'(blank),   32'd1);

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
